// File: rtl/video_pkg.sv
// Shared types and constants for the RGB->luma->threshold video path.
// Mode encoding, BT.601-style luma weights (sum 256) and pipeline latency.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_GRAY    = 2'd1,
        MODE_BIN     = 2'd2,
        MODE_BIN_INV = 2'd3
    } mode_e;

    localparam int COEF_R = 77;
    localparam int COEF_G = 150;
    localparam int COEF_B = 29;

    localparam int LAT = 4;

endpackage

// File: rtl/rgb_luma_pipe.sv
// Three-stage RGB->luma pipe (multiply, sum, truncate) with sideband
// and raw RGB delayed by the same three cycles.
module rgb_luma_pipe
    import video_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_vsync,
    input  logic            i_clken,
    input  logic            i_valid,
    input  logic [3*CW-1:0] i_rgb,
    output logic            o_vsync,
    output logic            o_clken,
    output logic            o_valid,
    output logic [CW-1:0]   o_luma,
    output logic [3*CW-1:0] o_rgb
);

    localparam int PW = CW + 8;
    localparam int SW = CW + 10;

    logic [CW-1:0]   w_r;
    logic [CW-1:0]   w_g;
    logic [CW-1:0]   w_b;
    logic [PW-1:0]   r_pr;
    logic [PW-1:0]   r_pg;
    logic [PW-1:0]   r_pb;
    logic [SW-1:0]   r_sum;
    logic [CW-1:0]   r_luma;
    logic [2:0]      r_sb  [3];
    logic [3*CW-1:0] r_rgb [3];

    assign w_r = i_rgb[3*CW-1:2*CW];
    assign w_g = i_rgb[2*CW-1:CW];
    assign w_b = i_rgb[CW-1:0];

    // S1 weights, S2 sums, S3 drops the 8 fraction bits (truncation)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr   <= '0;
            r_pg   <= '0;
            r_pb   <= '0;
            r_sum  <= '0;
            r_luma <= '0;
        end else begin
            r_pr   <= PW'(w_r) * PW'(COEF_R);
            r_pg   <= PW'(w_g) * PW'(COEF_G);
            r_pb   <= PW'(w_b) * PW'(COEF_B);
            r_sum  <= SW'(r_pr) + SW'(r_pg) + SW'(r_pb);
            r_luma <= r_sum[CW+7:8];
        end
    end

    // Sideband and raw RGB follow the arithmetic stage by stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_sb[i]  <= '0;
                r_rgb[i] <= '0;
            end
        end else begin
            r_sb[0]  <= {i_vsync, i_clken, i_valid};
            r_rgb[0] <= i_rgb;
            for (int i = 1; i < 3; i++) begin
                r_sb[i]  <= r_sb[i-1];
                r_rgb[i] <= r_rgb[i-1];
            end
        end
    end

    assign o_vsync = r_sb[2][2];
    assign o_clken = r_sb[2][1];
    assign o_valid = r_sb[2][0];
    assign o_luma  = r_luma;
    assign o_rgb   = r_rgb[2];

endmodule

// File: rtl/video_threshold_pipe.sv
// RGB passthrough / gray / binary / inverted-binary pixel pipeline, latency 4.
// Define AUTO_THRESH_EN to derive the threshold from the previous frame's mean luma.
module video_threshold_pipe
    import video_pkg::*;
#(
    parameter int CW          = 8,
    parameter int THRESH_INIT = 128,
    parameter int MODE_INIT   = 2,
    parameter int AVG_LOG2    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pre_image_vsync,
    input  logic            pre_image_clken,
    input  logic            pre_data_valid,
    input  logic [3*CW-1:0] pre_image_data,
    input  logic [1:0]      cfg_mode,
    input  logic [CW-1:0]   cfg_threshold,
    input  logic            cfg_auto,
    output logic            pos_image_vsync,
    output logic            pos_image_clken,
    output logic            pos_data_valid,
    output logic [3*CW-1:0] pos_image_data,
    output logic [CW-1:0]   stat_threshold
);

    logic            r_vs_d;
    logic            w_start;
    mode_e           r_mode;
    logic [CW-1:0]   r_thr;
    logic [CW-1:0]   w_thr_next;
    logic            w_s3_vs;
    logic            w_s3_ce;
    logic            w_s3_vld;
    logic [CW-1:0]   w_s3_luma;
    logic [3*CW-1:0] w_s3_rgb;
    logic            w_bin;

    rgb_luma_pipe #(
        .CW      (CW)
    ) u_luma (
        .clk     (clk),
        .rst     (rst),
        .i_vsync (pre_image_vsync),
        .i_clken (pre_image_clken),
        .i_valid (pre_data_valid),
        .i_rgb   (pre_image_data),
        .o_vsync (w_s3_vs),
        .o_clken (w_s3_ce),
        .o_valid (w_s3_vld),
        .o_luma  (w_s3_luma),
        .o_rgb   (w_s3_rgb)
    );

    assign w_start = pre_image_vsync & ~r_vs_d;

`ifdef AUTO_THRESH_EN
    localparam int AW   = CW + AVG_LOG2;
    localparam int CNTW = AVG_LOG2 + 1;

    logic [AW-1:0]   r_acc;
    logic [CNTW-1:0] r_cnt;
    logic            w_sat;
    logic            w_acc_en;
    logic [CW-1:0]   w_avg;

    assign w_sat    = r_cnt[AVG_LOG2];
    assign w_acc_en = w_s3_vld & w_s3_ce;
    assign w_avg    = r_acc[AW-1:AVG_LOG2];

    // Short frames under auto keep the old threshold
    assign w_thr_next = cfg_auto ? (w_sat ? w_avg : r_thr)
                                 : cfg_threshold;

    // Luma accumulator; the pixel in the start cycle opens the new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_start) begin
            r_acc <= w_acc_en ? AW'(w_s3_luma) : '0;
            r_cnt <= w_acc_en ? CNTW'(1) : '0;
        end else if (w_acc_en && !w_sat) begin
            r_acc <= r_acc + AW'(w_s3_luma);
            r_cnt <= r_cnt + CNTW'(1);
        end
    end
`else
    logic w_unused;

    assign w_unused   = cfg_auto & (AVG_LOG2 != 0);
    assign w_thr_next = cfg_threshold;
`endif

    // Frame-start latch of mode and threshold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d <= 1'b0;
            r_mode <= mode_e'(2'(MODE_INIT));
            r_thr  <= CW'(THRESH_INIT);
        end else begin
            r_vs_d <= pre_image_vsync;
            if (w_start) begin
                r_mode <= mode_e'(cfg_mode);
                r_thr  <= w_thr_next;
            end
        end
    end

    assign w_bin          = w_s3_luma > r_thr;
    assign stat_threshold = r_thr;

    // S4 output mux and final sideband register
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_image_vsync <= 1'b0;
            pos_image_clken <= 1'b0;
            pos_data_valid  <= 1'b0;
            pos_image_data  <= '0;
        end else begin
            pos_image_vsync <= w_s3_vs;
            pos_image_clken <= w_s3_ce;
            pos_data_valid  <= w_s3_vld;
            unique case (r_mode)
                MODE_PASS:    pos_image_data <= w_s3_rgb;
                MODE_GRAY:    pos_image_data <= {3{w_s3_luma}};
                MODE_BIN:     pos_image_data <= {3*CW{w_bin}};
                MODE_BIN_INV: pos_image_data <= {3*CW{~w_bin}};
                default:      pos_image_data <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_video_threshold_pipe.sv
// Scoreboard bench for video_threshold_pipe: directed pixels, hand-computed results.
// Auto-threshold checks are built when AUTO_THRESH_EN is defined.
module tb_video_threshold_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        pre_image_vsync;
    logic        pre_image_clken;
    logic        pre_data_valid;
    logic [23:0] pre_image_data;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_threshold;
    logic        cfg_auto;
    logic        pos_image_vsync;
    logic        pos_image_clken;
    logic        pos_data_valid;
    logic [23:0] pos_image_data;
    logic [7:0]  stat_threshold;

    always #5 clk = ~clk;

    video_threshold_pipe #(
        .CW              (8),
        .THRESH_INIT     (128),
        .MODE_INIT       (2),
        .AVG_LOG2        (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pre_image_vsync (pre_image_vsync),
        .pre_image_clken (pre_image_clken),
        .pre_data_valid  (pre_data_valid),
        .pre_image_data  (pre_image_data),
        .cfg_mode        (cfg_mode),
        .cfg_threshold   (cfg_threshold),
        .cfg_auto        (cfg_auto),
        .pos_image_vsync (pos_image_vsync),
        .pos_image_clken (pos_image_clken),
        .pos_data_valid  (pos_data_valid),
        .pos_image_data  (pos_image_data),
        .stat_threshold  (stat_threshold)
    );

    typedef struct {
        logic [23:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid output pops the oldest expected pixel
    always @(negedge clk) begin
        if (pos_data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(pos_data_valid), 32'd0);
            end else begin
                m_e = sb.pop_front();
                chk("data", 32'(pos_image_data), 32'(m_e.data));
                chk("latency", cyc, m_e.due);
                chk("clken", 32'(pos_image_clken), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [23:0] p, input logic [23:0] e);
        pre_data_valid  = 1'b1;
        pre_image_clken = 1'b1;
        pre_image_data  = p;
        sb.push_back('{e, cyc + 4});
    endtask

    task automatic idle(input int n);
        pre_data_valid  = 1'b0;
        pre_image_clken = 1'b0;
        pre_image_data  = 24'h0;
        repeat (n) tick();
    endtask

    task automatic vsync_pulse(input logic [7:0] exp_stat);
        int k0;
        pre_data_valid  = 1'b0;
        pre_image_clken = 1'b0;
        pre_image_vsync = 1'b1;
        k0 = cyc;
        tick();
        pre_image_vsync = 1'b0;
        @(negedge clk);
        chk("stat_thr", 32'(stat_threshold), 32'(exp_stat));
        tick();
        tick();
        @(negedge clk);
        chk("vsync_early", 32'(pos_image_vsync), 32'd0);
        chk("vsync_cyc3", cyc, k0 + 3);
        tick();
        @(negedge clk);
        chk("vsync_out", 32'(pos_image_vsync), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int k;
        rst             = 1'b1;
        pre_image_vsync = 1'b0;
        pre_image_clken = 1'b0;
        pre_data_valid  = 1'b0;
        pre_image_data  = 24'h0;
        cfg_mode        = 2'd0;
        cfg_threshold   = 8'd0;
        cfg_auto        = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", 32'(pos_data_valid), 32'd0);
        chk("rst_vsync", 32'(pos_image_vsync), 32'd0);
        chk("rst_clken", 32'(pos_image_clken), 32'd0);
        chk("rst_data", 32'(pos_image_data), 32'd0);
        chk("rst_stat", 32'(stat_threshold), 32'd128);
        tick();
        rst = 1'b0;

        // Default mode is binary at 128: white pixel stays white
        pix(24'hFFFFFF, 24'hFFFFFF);
        tick();
        idle(6);

        // Gray: 255*77+128*150+64*29 = 40691 -> 158
        cfg_mode      = 2'd1;
        cfg_threshold = 8'd100;
        vsync_pulse(8'd100);
        pix(24'hFF8040, 24'h9E9E9E);
        tick();
        pix(24'h646464, 24'h646464);
        tick();
        idle(6);

        // Binary at 100: equal -> black, above -> white
        cfg_mode = 2'd2;
        vsync_pulse(8'd100);
        pix(24'h646464, 24'h000000);
        tick();
        pix(24'h656565, 24'hFFFFFF);
        tick();
        idle(6);

        // Inverted binary
        cfg_mode = 2'd3;
        vsync_pulse(8'd100);
        pix(24'h646464, 24'hFFFFFF);
        tick();
        pix(24'h656565, 24'h000000);
        tick();

        // Mid-frame config change must wait for the next frame
        cfg_mode      = 2'd0;
        cfg_threshold = 8'd50;
        pix(24'h656565, 24'h000000);
        tick();
        pix(24'h000000, 24'hFFFFFF);
        tick();
        pix(24'h404040, 24'hFFFFFF);
        tick();
        idle(6);
        @(negedge clk);
        chk("stat_hold", 32'(stat_threshold), 32'd100);
        tick();
        vsync_pulse(8'd50);
        pix(24'hFF8040, 24'hFF8040);
        tick();
        pix(24'h123456, 24'h123456);
        tick();

        // Reset while streaming: in-flight pixels are dropped
        for (int i = 0; i < 6; i++) begin
            pix(24'h0A0B0C + 24'(i), 24'h0A0B0C + 24'(i));
            tick();
        end
        rst             = 1'b1;
        pre_data_valid  = 1'b0;
        pre_image_clken = 1'b0;
        k = cyc;
        @(negedge clk);
        #1;
        while (sb.size() != 0 && sb[$].due > k) void'(sb.pop_back());
        tick();
        @(negedge clk);
        chk("mrst_valid", 32'(pos_data_valid), 32'd0);
        chk("mrst_data", 32'(pos_image_data), 32'd0);
        chk("mrst_stat", 32'(stat_threshold), 32'd128);
        tick();
        rst = 1'b0;
        pix(24'h646464, 24'h000000);
        @(negedge clk);
        chk("post_rst_valid", 32'(pos_data_valid), 32'd0);
        tick();
        pix(24'h818181, 24'hFFFFFF);
        @(negedge clk);
        chk("post_rst_valid", 32'(pos_data_valid), 32'd0);
        tick();
        pix(24'h808080, 24'h000000);
        @(negedge clk);
        chk("post_rst_valid", 32'(pos_data_valid), 32'd0);
        tick();
        pix(24'hFFFFFF, 24'hFFFFFF);
        @(negedge clk);
        chk("post_rst_valid", 32'(pos_data_valid), 32'd0);
        tick();
        idle(6);

`ifdef AUTO_THRESH_EN
        // Four pixels since reset: short frame keeps 128
        cfg_auto      = 1'b1;
        cfg_threshold = 8'd200;
        cfg_mode      = 2'd2;
        vsync_pulse(8'd128);
        for (int i = 0; i < 16; i++) begin
            pix(24'h3C3C3C, 24'h000000);
            tick();
        end
        idle(6);
        vsync_pulse(8'd60);
        for (int i = 0; i < 14; i++) begin
            pix(24'h3C3C3C, 24'h000000);
            tick();
        end
        pix(24'h3D3D3D, 24'hFFFFFF);
        tick();
        idle(6);
        vsync_pulse(8'd60);
        cfg_auto = 1'b0;
        vsync_pulse(8'd200);
`else
        // Without the auto feature cfg_auto is ignored
        cfg_auto      = 1'b1;
        cfg_threshold = 8'd200;
        cfg_mode      = 2'd2;
        vsync_pulse(8'd200);
        pix(24'hC9C9C9, 24'hFFFFFF);
        tick();
        pix(24'hC8C8C8, 24'h000000);
        tick();
        idle(6);
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
